// File: rtl/puf_serial_link_if.sv
// Host/core bundle for the PUF serial link.
// Carries the host enable and debug pulse, the bit-serial rx (challenge) and tx (response)
// handshakes, the parallel challenge hand-off to the core, the core response strobe, and the
// outstanding/overflow status.
//   master : the link itself (drives the o_* signals)
//   slave  : the host/core side (drives the i_* signals)
interface puf_serial_link_if #(
  parameter int unsigned CHAL_W     = 40,
  parameter int unsigned DBG_W      = 133,
  parameter int unsigned RESP_DEPTH = 4
);
  localparam int unsigned OutW = $clog2(RESP_DEPTH) + 1;

  logic              i_start;
  logic              i_op_mode;
  logic              o_rx_ready;
  logic              i_rx_valid;
  logic              i_rx_data;
  logic              i_tx_ready;
  logic              o_tx_valid;
  logic              o_tx_data;
  logic              o_chal_valid;
  logic [CHAL_W-1:0] o_chal_data;
  logic              o_chal_dbg;
  logic              i_chal_ready;
  logic              i_resp_valid;
  logic              i_resp_dbg;
  logic [DBG_W-1:0]  i_resp_data;
  logic [OutW-1:0]   o_outstanding;
  logic              o_err_ovf;

  modport master (
    input  i_start, i_op_mode, i_rx_valid, i_rx_data, i_tx_ready, i_chal_ready,
           i_resp_valid, i_resp_dbg, i_resp_data,
    output o_rx_ready, o_tx_valid, o_tx_data, o_chal_valid, o_chal_data, o_chal_dbg,
           o_outstanding, o_err_ovf
  );

  modport slave (
    output i_start, i_op_mode, i_rx_valid, i_rx_data, i_tx_ready, i_chal_ready,
           i_resp_valid, i_resp_dbg, i_resp_data,
    input  o_rx_ready, o_tx_valid, o_tx_data, o_chal_valid, o_chal_data, o_chal_dbg,
           o_outstanding, o_err_ovf
  );
endinterface

// File: rtl/puf_serial_link.sv
// Bit-serial host link between the external host pins and the PUF core.
//   Rx: deserialises CHAL_W-bit challenges (LSB first) and offers them to the core as a word,
//       tagged debug if an i_op_mode pulse was seen since the previous issue.
//   Tx: queues core responses in a RESP_DEPTH-frame FIFO and serialises them LSB first,
//       NORM_W or DBG_W bits per frame, honouring i_tx_ready back-pressure.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : puf_serial_link_if master modport (host rx/tx, core challenge/response, status)
module puf_serial_link #(
  parameter int unsigned CHAL_W     = 40,
  parameter int unsigned NORM_W     = 34,
  parameter int unsigned DBG_W      = 133,
  parameter int unsigned RESP_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  puf_serial_link_if.master bus
);
  localparam int unsigned OutW   = $clog2(RESP_DEPTH) + 1;
  localparam int unsigned PtrW   = $clog2(RESP_DEPTH);
  localparam int unsigned RxCntW = $clog2(CHAL_W);
  localparam int unsigned TxCntW = $clog2(DBG_W);
  localparam int unsigned EntW   = DBG_W + 1;
  localparam logic [DBG_W-1:0] NormMask = DBG_W'({NORM_W{1'b1}});

  typedef enum logic [1:0] {StIdle, StRx, StIssue} state_e;

  state_e              state_q, state_d;
  logic [RxCntW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic                dbg_pend_q, dbg_pend_d;
  logic [OutW-1:0]     outst_q, outst_d;
  logic                err_ovf_q, err_ovf_d;

  logic [EntW-1:0]     fifo_q [RESP_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [OutW-1:0]     fifo_cnt_q, fifo_cnt_d;

  logic                tx_busy_q, tx_busy_d;
  logic [DBG_W-1:0]    tx_sr_q, tx_sr_d;
  logic                tx_dbg_q, tx_dbg_d;
  logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;

  logic                rx_accept, rx_last, issue_hs, credit;
  logic                tx_fire, tx_done, push, pop, full, out_dec, load;
  logic [TxCntW-1:0]   tx_last_idx;
  logic [PtrW-1:0]     rd_nxt;
  logic [EntW-1:0]     load_ent;

  assign rx_accept = (state_q == StRx) && bus.i_rx_valid;
  assign rx_last   = rx_accept && (rx_cnt_q == RxCntW'(CHAL_W - 1));
  assign issue_hs  = (state_q == StIssue) && bus.i_chal_ready;
  assign credit    = outst_q < OutW'(RESP_DEPTH);

  // Rx FSM: the word register is only ever written bit-by-bit, so a frame that was cut short
  // by reset is fully overwritten by the next one.
  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    chal_d   = chal_q;
    case (state_q)
      StIdle: begin
        if (bus.i_start && credit) begin
          state_d  = StRx;
          rx_cnt_d = '0;
        end
      end
      StRx: begin
        if (rx_accept) begin
          chal_d[rx_cnt_q] = bus.i_rx_data;
          rx_cnt_d         = rx_cnt_q + RxCntW'(1);
          if (rx_last) state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.i_chal_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A pulse coinciding with the handshake is consumed by that challenge.
  assign dbg_pend_d = issue_hs ? 1'b0 : (dbg_pend_q | bus.i_op_mode);

  // Response FIFO: the head stays queued while it is being serialised and is popped only when
  // its last bit is accepted, so a full FIFO includes the frame on the wire.
  assign tx_fire     = tx_busy_q && bus.i_tx_ready;
  assign tx_last_idx = tx_dbg_q ? TxCntW'(DBG_W - 1) : TxCntW'(NORM_W - 1);
  assign tx_done     = tx_fire && (tx_cnt_q == tx_last_idx);
  assign pop         = tx_done;
  assign full        = fifo_cnt_q == OutW'(RESP_DEPTH);
  assign push        = bus.i_resp_valid && (!full || pop);
  assign rd_nxt      = rd_ptr_q + PtrW'(1);
  assign err_ovf_d   = err_ovf_q | (bus.i_resp_valid && full && !pop);

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + OutW'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - OutW'(1);
  end

  // Tx serialiser. On frame completion the next frame is loaded in the same cycle, either from
  // the entry behind the head or, if that slot is being written right now, straight from the
  // incoming response.
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_sr_d   = tx_sr_q;
    tx_dbg_d  = tx_dbg_q;
    tx_cnt_d  = tx_cnt_q;
    load      = 1'b0;
    load_ent  = '0;
    if (!tx_busy_q) begin
      if (fifo_cnt_q != '0) begin
        load     = 1'b1;
        load_ent = fifo_q[rd_ptr_q];
      end
    end else if (tx_done) begin
      if (fifo_cnt_q > OutW'(1)) begin
        load     = 1'b1;
        load_ent = fifo_q[rd_nxt];
      end else if (bus.i_resp_valid) begin
        load     = 1'b1;
        load_ent = {bus.i_resp_dbg, bus.i_resp_data};
      end else begin
        tx_busy_d = 1'b0;
      end
    end else if (tx_fire) begin
      tx_sr_d  = tx_sr_q >> 1;
      tx_cnt_d = tx_cnt_q + TxCntW'(1);
    end
    if (load) begin
      tx_busy_d = 1'b1;
      tx_dbg_d  = load_ent[DBG_W];
      tx_sr_d   = load_ent[DBG_W-1:0] & (load_ent[DBG_W] ? {DBG_W{1'b1}} : NormMask);
      tx_cnt_d  = '0;
    end
  end

  // Credit cannot go past RESP_DEPTH: it only grows at issue, and RX is entered only below it.
  assign out_dec = tx_done && (outst_q != '0);
  always_comb begin
    outst_d = outst_q;
    if (issue_hs && !out_dec)      outst_d = outst_q + OutW'(1);
    else if (!issue_hs && out_dec) outst_d = outst_q - OutW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rx_cnt_q   <= '0;
      chal_q     <= '0;
      dbg_pend_q <= 1'b0;
      outst_q    <= '0;
      err_ovf_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      tx_busy_q  <= 1'b0;
      tx_sr_q    <= '0;
      tx_dbg_q   <= 1'b0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      chal_q     <= chal_d;
      dbg_pend_q <= dbg_pend_d;
      outst_q    <= outst_d;
      err_ovf_q  <= err_ovf_d;
      fifo_cnt_q <= fifo_cnt_d;
      tx_busy_q  <= tx_busy_d;
      tx_sr_q    <= tx_sr_d;
      tx_dbg_q   <= tx_dbg_d;
      tx_cnt_q   <= tx_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_nxt;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {bus.i_resp_dbg, bus.i_resp_data};
  end

  assign bus.o_rx_ready    = state_q == StRx;
  assign bus.o_chal_valid  = state_q == StIssue;
  assign bus.o_chal_data   = chal_q;
  assign bus.o_chal_dbg    = (state_q == StIssue) && (dbg_pend_q || bus.i_op_mode);
  assign bus.o_tx_valid    = tx_busy_q;
  assign bus.o_tx_data     = tx_sr_q[0];
  assign bus.o_outstanding = outst_q;
  assign bus.o_err_ovf     = err_ovf_q;
endmodule
